vce_cram_arbiter: RTL and testbench

//  Owns the single-port, synchronous palette RAM (CRAM) of the VCE.

---
 rtl/vce_pkg.sv | 23 ++
 rtl/vce_cram_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_vce_cram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vce_pkg.sv
// -----------------------------------------------------------------------------
// vce_pkg
// Shared VCE definitions: palette RAM (CRAM) geometry, address/data types and
// the CRAM arbiter state encoding. Imported by vce_cram_arbiter and
// vce_HuC6260.
// -----------------------------------------------------------------------------
package vce_pkg;

    localparam int unsigned CRAM_ADDR_W = 9;
    localparam int unsigned CRAM_DATA_W = 9;
    localparam int unsigned CRAM_DEPTH  = 1 << CRAM_ADDR_W;

    // CRAM entry layout is GGGRRRBBB.
    typedef logic [CRAM_ADDR_W-1:0] cram_addr_t;
    typedef logic [CRAM_DATA_W-1:0] cram_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // no CPU access pending
        PEND = 2'd1,    // CPU access waiting for a RAM slot
        ACK  = 2'd2     // cycle after the CPU access, cpu_ack asserted
    } arb_state_t;

endpackage

// File: rtl/vce_cram_arbiter.sv
// -----------------------------------------------------------------------------
// vce_cram_arbiter
// Owns the single-port synchronous palette RAM (CRAM) and shares it between the
// hard real-time pixel fetch path and the CPU colour-table MMIO path.
//
// Ports
//   clock, reset_N           system clock, asynchronous active-low reset
//   pix_req, pix_addr        dot-clock read strobe and colour index
//   pix_valid, pix_data      colour entry, one cycle after pix_req
//   pix_stale                with pix_valid: slot was lost to the CPU
//   cpu_req/we/addr/wdata    CPU access, level request held until cpu_ack
//   cpu_ack, cpu_rdata       completion pulse, read data held until next read
//   ram_en/we/addr/wdata     CRAM port, driven combinationally from the grant
//   ram_rdata                CRAM registered read data
//
// Configuration
//   VCE_ACCESS_ARTIFACT_EN   defined: CPU always wins the port and a lost pixel
//                            slot shows the CPU-accessed entry (palette-write
//                            glitch). Undefined: pixel priority with a bounded
//                            CPU deferral and stale-repeat of the last colour.
// -----------------------------------------------------------------------------
module vce_cram_arbiter
    import vce_pkg::*;
#(
    parameter int unsigned ADDR_W    = CRAM_ADDR_W,
    parameter int unsigned DATA_W    = CRAM_DATA_W,
    parameter int unsigned MAX_DEFER = 3
) (
    input  logic              clock,
    input  logic              reset_N,

    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_stale,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;

    logic              cpu_pending;
    logic              cpu_grant;
    logic              pix_grant;

    // Pixel pipeline: which kind of slot the previous cycle produced.
    logic              pix_rd_q;
    logic              pix_lost_q;
    logic [DATA_W-1:0] pix_hold_q;

    // Last-cycle CPU write, kept for read-after-write forwarding.
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              fwd_d, fwd_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic              acc_we_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // -------------------------------------------------------------------------
    // Grant decision
    // -------------------------------------------------------------------------
`ifdef VCE_ACCESS_ARTIFACT_EN
    logic [DATA_W-1:0] acc_wdata_q;

    always_comb begin
        // Reset gates every request so the port stays quiet during reset.
        cpu_pending = reset_N & ((state_q == PEND) | ((state_q == IDLE) & cpu_req));
        cpu_grant   = cpu_pending;
        pix_grant   = reset_N & pix_req & ~cpu_grant;
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            acc_wdata_q <= '0;
        end else if (cpu_grant) begin
            acc_wdata_q <= cpu_wdata;
        end
    end
`else
    localparam int unsigned DEFER_W = $clog2(MAX_DEFER + 1);
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);

    logic [DEFER_W-1:0] defer_q, defer_d;

    always_comb begin
        cpu_pending = reset_N & ((state_q == PEND) | ((state_q == IDLE) & cpu_req));
        cpu_grant   = cpu_pending & (~pix_req | (defer_q == DEFER_MAX));
        pix_grant   = reset_N & pix_req & ~cpu_grant;
    end

    // Counts pixel slots the pending CPU access has lost; saturating, so the
    // CPU is guaranteed the port after MAX_DEFER consecutive losses.
    always_comb begin
        defer_d = defer_q;
        if (cpu_grant) begin
            defer_d = '0;
        end else if (cpu_pending && pix_req && (defer_q != DEFER_MAX)) begin
            defer_d = defer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // CPU access FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_pending) begin
                    state_d = cpu_grant ? ACK : PEND;
                end
            end
            PEND: begin
                if (cpu_grant) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // RAM port
    // -------------------------------------------------------------------------
    always_comb begin
        ram_en    = cpu_grant | pix_grant;
        ram_we    = cpu_grant & cpu_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_grant) begin
            ram_addr = cpu_addr;
            if (cpu_we) begin
                ram_wdata = cpu_wdata;
            end
        end else if (pix_grant) begin
            ram_addr = pix_addr;
        end
    end

    // A pixel read right after a CPU write to the same entry takes the written
    // value directly instead of relying on the RAM's read-first behaviour.
    assign fwd_d = pix_grant & wr_valid_q & (pix_addr == wr_addr_q);

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            pix_rd_q    <= 1'b0;
            pix_lost_q  <= 1'b0;
            pix_hold_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            acc_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            pix_rd_q    <= pix_grant;
            pix_lost_q  <= pix_req & cpu_grant;
            pix_hold_q  <= pix_data;
            wr_valid_q  <= cpu_grant & cpu_we;
            wr_addr_q   <= cpu_addr;
            wr_data_q   <= cpu_wdata;
            fwd_q       <= fwd_d;
            fwd_data_q  <= wr_data_q;
            if (cpu_grant) begin
                acc_we_q <= cpu_we;
            end
            cpu_rdata_q <= cpu_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pix_data = pix_hold_q;
        if (pix_rd_q) begin
            pix_data = fwd_q ? fwd_data_q : ram_rdata;
        end else if (pix_lost_q) begin
`ifdef VCE_ACCESS_ARTIFACT_EN
            // The lost slot shows whatever entry the CPU touched.
            pix_data = acc_we_q ? acc_wdata_q : ram_rdata;
`else
            pix_data = pix_hold_q;
`endif
        end
    end

    assign pix_valid = pix_rd_q | pix_lost_q;
    assign pix_stale = pix_lost_q;
    assign cpu_ack   = (state_q == ACK);
    assign cpu_rdata = ((state_q == ACK) && !acc_we_q) ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vce_cram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vce_cram_arbiter
// Scoreboard bench for vce_cram_arbiter: directed stimulus pushes expected pixel
// and CPU responses into queues, a monitor pops and compares on pix_valid and
// cpu_ack. A behavioural read-first CRAM is attached to the RAM port.
// -----------------------------------------------------------------------------
module tb_vce_cram_arbiter;
    import vce_pkg::*;

    logic       clock   = 1'b0;
    logic       reset_N = 1'b1;

    logic       pix_req   = 1'b0;
    cram_addr_t pix_addr  = '0;
    logic       pix_valid;
    cram_data_t pix_data;
    logic       pix_stale;
    logic       cpu_req   = 1'b0;
    logic       cpu_we    = 1'b0;
    cram_addr_t cpu_addr  = '0;
    cram_data_t cpu_wdata = '0;
    logic       cpu_ack;
    cram_data_t cpu_rdata;
    logic       ram_en;
    logic       ram_we;
    cram_addr_t ram_addr;
    cram_data_t ram_wdata;
    cram_data_t ram_rdata = '0;

    always #5 clock = ~clock;

    vce_cram_arbiter #(
        .ADDR_W    (9),
        .DATA_W    (9),
        .MAX_DEFER (3)
    ) dut (
        .clock     (clock),
        .reset_N   (reset_N),
        .pix_req   (pix_req),
        .pix_addr  (pix_addr),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_stale (pix_stale),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // ---------------- CRAM model (read-first, registered read) ----------------
    cram_data_t mem     [CRAM_DEPTH];
    cram_data_t ref_mem [CRAM_DEPTH];
    logic       mem_loaded = 1'b0;

    function automatic cram_data_t init_val(int unsigned i);
        if (i == 32'h010) return 9'h1C7;
        return cram_data_t'((i * 7 + 3) & 32'h1FF);
    endfunction

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int unsigned i = 0; i < CRAM_DEPTH; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        cram_data_t data;
        logic       stale;
    } pix_exp_t;

    pix_exp_t    pix_q [$];
    cram_data_t  cpu_q [$];
    cram_data_t  last_rd = '0;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_pix(cram_data_t d, logic s);
        pix_exp_t e;
        e.data  = d;
        e.stale = s;
        pix_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (reset_N) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", 32'(pix_valid), 32'd0);
                end else begin
                    pix_exp_t e;
                    e = pix_q.pop_front();
                    chk("pix_data",  32'(pix_data),  32'(e.data));
                    chk("pix_stale", 32'(pix_stale), 32'(e.stale));
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                end else begin
                    cram_data_t d;
                    d = cpu_q.pop_front();
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(d));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one CPU access; lat = cycles from request cycle to ack cycle.
    task automatic cpu_access(input logic we, input cram_addr_t addr, input cram_data_t wdata,
                              output int unsigned lat);
        if (we) begin
            cpu_q.push_back(last_rd);
            ref_mem[addr] = wdata;
        end else begin
            cpu_q.push_back(ref_mem[addr]);
            last_rd = ref_mem[addr];
        end
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        lat = 0;
        forever begin
            @(negedge clock);
            if (cpu_ack) break;
            lat++;
            if (lat > 20) begin
                chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
                break;
            end
            tick();
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic pix_burst(input cram_addr_t base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            pix_req  = 1'b1;
            pix_addr = cram_addr_t'(32'(base) + i);
            tick();
        end
        pix_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
        chk({tag, "_pix_stale"}, 32'(pix_stale), 32'd0);
        chk({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        chk({tag, "_ram_en"},    32'(ram_en),    32'd0);
        chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
        chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int unsigned lat;
        for (int unsigned i = 0; i < CRAM_DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset
        #1 reset_N = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        tick();
        reset_N = 1'b1;
        tick();

        // 1: plain pixel read of CRAM[0x010]
        push_pix(9'h1C7, 1'b0);
        pix_burst(9'h010, 1);
        tick();

        // 2: CPU write 0x0AA to 0x1FF with no pixel traffic, then read back
        fork
            cpu_access(1'b1, 9'h1FF, 9'h0AA, lat);
            begin
                @(negedge clock);
                chk("t2_ram_en",    32'(ram_en),    32'd1);
                chk("t2_ram_we",    32'(ram_we),    32'd1);
                chk("t2_ram_addr",  32'(ram_addr),  32'h1FF);
                chk("t2_ram_wdata", 32'(ram_wdata), 32'h0AA);
            end
        join
        chk("t2_write_latency", lat, 32'd1);
        cpu_access(1'b0, 9'h1FF, 9'h000, lat);
        chk("t2_read_latency", lat, 32'd1);

        // Pixel wins one slot, CPU granted as soon as pix_req drops
        push_pix(ref_mem[9'h011], 1'b0);
        fork
            cpu_access(1'b0, 9'h1FF, 9'h000, lat);
            pix_burst(9'h011, 1);
        join
        chk("defer1_latency", lat, 32'd2);
        tick();

        // 3: pix_req every cycle, CPU read forced in on the 4th cycle
        push_pix(ref_mem[9'h020], 1'b0);
        push_pix(ref_mem[9'h021], 1'b0);
        push_pix(ref_mem[9'h022], 1'b0);
        push_pix(ref_mem[9'h022], 1'b1);
        push_pix(ref_mem[9'h024], 1'b0);
        push_pix(ref_mem[9'h025], 1'b0);
        push_pix(ref_mem[9'h026], 1'b0);
        fork
            cpu_access(1'b0, 9'h100, 9'h000, lat);
            pix_burst(9'h020, 7);
        join
        chk("t3_max_defer_latency", lat, 32'd4);
        tick();

        // 4: pixel read of an entry written the previous cycle
        push_pix(9'h155, 1'b0);
        fork
            cpu_access(1'b1, 9'h005, 9'h155, lat);
            begin
                tick();
                pix_burst(9'h005, 1);
            end
        join
        tick();

        // 5: pixel request and CPU write in the same cycle
`ifdef VCE_ACCESS_ARTIFACT_EN
        push_pix(9'h07F, 1'b1);
`else
        push_pix(ref_mem[9'h040], 1'b0);
`endif
        fork
            cpu_access(1'b1, 9'h030, 9'h07F, lat);
            pix_burst(9'h040, 1);
        join
`ifdef VCE_ACCESS_ARTIFACT_EN
        chk("t5_latency", lat, 32'd1);
`else
        chk("t5_latency", lat, 32'd2);
`endif
        cpu_access(1'b0, 9'h030, 9'h000, lat);
        chk("t5_readback_latency", lat, 32'd1);

        // 6: reset while a CPU write is pending behind a pixel read
        pix_req   = 1'b1;
        pix_addr  = 9'h050;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 9'h060;
        cpu_wdata = 9'h111;
        tick();
`ifdef VCE_ACCESS_ARTIFACT_EN
        ref_mem[9'h060] = 9'h111;
`endif
        reset_N = 1'b0;
        @(negedge clock);
        chk_all_zero("t6_reset");
        pix_req = 1'b0;
        cpu_req = 1'b0;
        tick();
        reset_N = 1'b1;
        repeat (3) tick();
        last_rd = '0;
        cpu_access(1'b0, 9'h060, 9'h000, lat);
        chk("t6_idle_latency", lat, 32'd1);

        repeat (3) tick();
        chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
